// File: rtl/rv32_imm_decode_ctrl_if.sv
// Fetch-to-execute handshake bundle for the RV32 immediate decode stage.
// The master side is fetch plus execute (the testbench); the slave side is the decoder.
interface rv32_imm_decode_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic [2:0]      out_imm_type;
   logic [XLEN-1:0] out_imm;
   logic            out_has_imm;
   logic            out_illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_imm_type,
             out_imm, out_has_imm, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_imm_type,
             out_imm, out_has_imm, out_illegal
   );
endinterface

// File: rtl/rv32_imm_decode_ctrl.sv
// RV32 immediate decoder with a registered two-entry skid buffer toward execute.
// Decode is combinational on the input side; the main entry drives every output,
// and the skid entry absorbs one cycle of downstream backpressure.
module rv32_imm_decode_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input logic                  clk,
   input logic                  rst,
   rv32_imm_decode_ctrl_if.slave io
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [2:0]      imm_type;
      logic [XLEN-1:0] imm;
      logic            has_imm;
      logic            illegal;
   } entry_t;

   state_t state;
   entry_t main_e;
   entry_t skid_e;
   entry_t dec;

   logic [XLEN-1:0] instr;
   logic            accept;
   logic            pop;

   assign instr = io.in_instr;

   // Both handshake outputs are decodes of the state register only.
   assign io.in_ready  = (state != FULL);
   assign io.out_valid = (state != EMPTY);

   assign accept = io.in_valid & io.in_ready;
   assign pop    = io.out_valid & io.out_ready;

   // Classify the opcode and build the extended immediate for the incoming word.
   always_comb begin
      dec          = '0;
      dec.pc       = io.in_pc;
      dec.instr    = instr;
      dec.has_imm  = 1'b1;
      case (instr[6:0])
         7'b0000011, 7'b0010011: begin
            dec.imm_type = 3'b000;
            dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         7'b1100111: begin
            dec.imm_type = 3'b001;
            dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         7'b0100011: begin
            dec.imm_type = 3'b010;
            dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         end
         7'b1100011: begin
            dec.imm_type = 3'b011;
            dec.imm      = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec.imm_type = 3'b100;
            dec.imm      = {instr[31:12], {(XLEN-20){1'b0}}};
         end
         7'b1101111: begin
            dec.imm_type = 3'b101;
            dec.imm      = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
         end
         7'b1110011: begin
            if (instr[14]) begin
               dec.imm_type = 3'b110;
               dec.imm      = {{(XLEN-5){1'b0}}, instr[19:15]};
            end else begin
               dec.imm_type = 3'b111;
               dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
         end
         7'b0001111: begin
            dec.imm_type = 3'b111;
            dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
         end
         7'b0110011: begin
            dec.has_imm = 1'b0;
         end
         default: begin
            dec.has_imm = 1'b0;
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Buffer occupancy FSM; flush wins over any same-cycle accept or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         main_e <= '0;
         skid_e <= '0;
      end else if (io.flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_e <= dec;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_e <= dec;
               end else if (accept) begin
                  skid_e <= dec;
                  state  <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_e <= skid_e;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign io.out_pc       = main_e.pc;
   assign io.out_instr    = main_e.instr;
   assign io.out_imm_type = main_e.imm_type;
   assign io.out_imm      = main_e.imm;
   assign io.out_has_imm  = main_e.has_imm;
   assign io.out_illegal  = main_e.illegal;

endmodule

// File: tb/tb_rv32_imm_decode_ctrl.sv
// Self-checking bench for rv32_imm_decode_ctrl: directed decode vectors, stall,
// flush, asynchronous reset and a randomised handshake stream against a queue model.
module tb_rv32_imm_decode_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [2:0]  typ;
      logic [31:0] imm;
      logic        has;
      logic        ill;
   } ent_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rv32_imm_decode_ctrl_if #(.XLEN(32)) io ();

   rv32_imm_decode_ctrl #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   ent_t         q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   logic         stalled_prev = 1'b0;
   logic [100:0] prev_snap = '0;
   logic [31:0]  pc_base = 32'h0000_1000;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [2:0] typ, input logic [31:0] imm,
                               input logic has, input logic ill);
      ent_t e;
      e.pc = pc; e.instr = instr; e.typ = typ; e.imm = imm; e.has = has; e.ill = ill;
      return e;
   endfunction

   // Reference decode using arithmetic shifts of left-justified fields.
   function automatic ent_t ref_dec(input logic [31:0] pc, input logic [31:0] i);
      ent_t               e;
      logic signed [31:0] t;
      e = mk(pc, i, 3'd0, 32'd0, 1'b1, 1'b0);
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h0F: begin
            t = i;
            e.imm = t >>> 20;
            e.typ = (i[6:0] == 7'h67) ? 3'd1 : (i[6:0] == 7'h0F) ? 3'd7 : 3'd0;
         end
         7'h23: begin
            t = {i[31:25], i[11:7], 20'd0};
            e.imm = t >>> 20; e.typ = 3'd2;
         end
         7'h63: begin
            t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0};
            e.imm = t >>> 19; e.typ = 3'd3;
         end
         7'h37, 7'h17: begin
            e.imm = i & 32'hFFFF_F000; e.typ = 3'd4;
         end
         7'h6F: begin
            t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0};
            e.imm = t >>> 11; e.typ = 3'd5;
         end
         7'h73: begin
            if (i[14]) begin
               e.imm = (i >> 15) & 32'h1F; e.typ = 3'd6;
            end else begin
               t = i;
               e.imm = t >>> 20; e.typ = 3'd7;
            end
         end
         7'h33: e.has = 1'b0;
         default: begin
            e.has = 1'b0; e.ill = 1'b1;
         end
      endcase
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0]  ops [12];
      logic [31:0] w;
      int unsigned k;
      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F, 7'h33, 7'h00};
      w = $urandom;
      k = $urandom_range(0, 11);
      if (k < 11) w[6:0] = ops[k];
      return w;
   endfunction

   // One cycle at the falling edge: check outputs against the model, drive inputs, advance the model.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic rdy, input logic fl, input ent_t exp_e, output logic acc);
      logic         pop;
      logic [100:0] snap;
      snap = {io.out_pc, io.out_instr, io.out_imm_type, io.out_imm, io.out_has_imm, io.out_illegal};
      check("out_valid", io.out_valid, q.size() != 0);
      check("in_ready", io.in_ready, q.size() < 2);
      if (q.size() != 0) begin
         check("out_pc", io.out_pc, q[0].pc);
         check("out_instr", io.out_instr, q[0].instr);
         check("out_imm_type", io.out_imm_type, q[0].typ);
         check("out_imm", io.out_imm, q[0].imm);
         check("out_has_imm", io.out_has_imm, q[0].has);
         check("out_illegal", io.out_illegal, q[0].ill);
      end
      if (stalled_prev) check("hold_stable", snap, prev_snap);
      prev_snap    = snap;
      stalled_prev = (q.size() != 0) && !rdy && !fl;
      io.in_valid  = v;
      io.in_pc     = pc;
      io.in_instr  = instr;
      io.out_ready = rdy;
      io.flush     = fl;
      acc = v && (q.size() < 2) && !fl;
      pop = (q.size() != 0) && rdy;
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(exp_e);
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] instr, input logic [2:0] typ,
                       input logic [31:0] imm, input logic has, input logic ill);
      logic acc;
      cycle(1'b1, pc_base, instr, 1'b1, 1'b0, mk(pc_base, instr, typ, imm, has, ill), acc);
      pc_base += 4;
   endtask

   task automatic idle(input int n, input logic rdy);
      logic acc;
      for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 32'd0, rdy, 1'b0, '0, acc);
   endtask

   // mode 0: out_ready low for the first three cycles, in_valid always high; mode 1: random.
   task automatic run_stream(input int n, input int mode);
      int          sent;
      int          cyc;
      logic [31:0] ins;
      logic        v;
      logic        r;
      logic        acc;
      sent = 0;
      cyc  = 0;
      ins  = gen_instr();
      while ((sent < n || q.size() != 0) && cyc < 20 * n + 100) begin
         if (mode == 1) begin
            v = (sent < n) && ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
         end else begin
            v = (sent < n);
            r = (cyc >= 3);
         end
         cycle(v, pc_base, ins, r, 1'b0, ref_dec(pc_base, ins), acc);
         if (acc) begin
            sent++;
            pc_base += 4;
            ins = gen_instr();
         end
         cyc++;
      end
      check("stream_drained", (sent == n) && (q.size() == 0), 1'b1);
   endtask

   initial begin
      logic acc;
      rst          = 1'b1;
      io.flush     = 1'b0;
      io.in_valid  = 1'b0;
      io.in_instr  = '0;
      io.in_pc     = '0;
      io.out_ready = 1'b0;
      #2;
      check("rst_out_valid", io.out_valid, 1'b0);
      check("rst_in_ready", io.in_ready, 1'b1);
      check("rst_out_pc", io.out_pc, 32'd0);
      check("rst_out_instr", io.out_instr, 32'd0);
      check("rst_out_imm", io.out_imm, 32'd0);
      check("rst_out_type", {io.out_imm_type, io.out_has_imm, io.out_illegal}, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back directed decode vectors, each visible one cycle after acceptance.
      send(32'hFFF00093, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      send(32'h0020A423, 3'd2, 32'h0000_0008, 1'b1, 1'b0);
      send(32'hFE000EE3, 3'd3, 32'hFFFF_FFFC, 1'b1, 1'b0);
      send(32'h123452B7, 3'd4, 32'h1234_5000, 1'b1, 1'b0);
      idle(1, 1'b1);
      send(32'h3002D073, 3'd6, 32'h0000_0005, 1'b1, 1'b0);
      send(32'h00000033, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
      send(32'h0000007F, 3'd0, 32'h0000_0000, 1'b0, 1'b1);
      send(32'h008000EF, 3'd5, 32'h0000_0008, 1'b1, 1'b0);
      send(32'h00008067, 3'd1, 32'h0000_0000, 1'b1, 1'b0);
      send(32'h0FF0000F, 3'd7, 32'h0000_00FF, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Three-cycle stall while streaming: two accepted, then in_ready drops, then drain in order.
      run_stream(6, 0);

      // Flush while FULL with a new input present; that input must never appear.
      cycle(1'b1, pc_base, 32'h00100093, 1'b0, 1'b0, ref_dec(pc_base, 32'h00100093), acc);
      pc_base += 4;
      cycle(1'b1, pc_base, 32'h00200093, 1'b0, 1'b0, ref_dec(pc_base, 32'h00200093), acc);
      pc_base += 4;
      cycle(1'b1, pc_base, 32'h00300093, 1'b1, 1'b1, ref_dec(pc_base, 32'h00300093), acc);
      pc_base += 4;
      idle(1, 1'b1);
      send(32'h00400093, 3'd0, 32'h0000_0004, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Asynchronous reset between clock edges with two entries buffered.
      cycle(1'b1, pc_base, 32'hABCDE037, 1'b0, 1'b0, ref_dec(pc_base, 32'hABCDE037), acc);
      pc_base += 4;
      cycle(1'b1, pc_base, 32'hFFF00093, 1'b0, 1'b0, ref_dec(pc_base, 32'hFFF00093), acc);
      pc_base += 4;
      io.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", io.out_valid, 1'b0);
      check("arst_out_imm", io.out_imm, 32'd0);
      check("arst_in_ready", io.in_ready, 1'b1);
      q.delete();
      stalled_prev = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      send(32'h00500113, 3'd0, 32'h0000_0005, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Randomised handshakes against the reference decode.
      run_stream(1000, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv32_imm_decode_ctrl.md
# rv32_imm_decode_ctrl

Decode-stage controller that accepts fetched RV32 instructions over a valid/ready handshake and classifies each opcode into an immediate type. It computes the sign- or zero-extended 32-bit immediate and presents the result to the execute stage through a registered two-entry skid buffer. It sits between fetch and the register-read/execute stage and absorbs one cycle of downstream backpressure without losing throughput.

## Interface
- `XLEN`, 32, instruction, PC and immediate width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of all buffered entries (branch redirect).
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  block can accept this cycle.
- `in_instr`  in  XLEN  raw instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  decoded entry available.
- `out_ready`  in  1  execute consumes the entry this cycle.
- `out_pc`  out  XLEN  PC of the presented entry.
- `out_instr`  out  XLEN  instruction of the presented entry.
- `out_imm_type`  out  3  immediate class code.
- `out_imm`  out  XLEN  extended immediate.
- `out_has_imm`  out  1  instruction uses an immediate.
- `out_illegal`  out  1  opcode is not recognised.

## Operation
- Immediate class is selected by `opcode = instr[6:0]`:
  - 000: I-type, for LOAD 0000011 and OP-IMM 0010011.
  - 001: I-type, for JALR 1100111.
  - 010: S-type, for STORE 0100011.
  - 011: B-type, for BRANCH 1100011.
  - 100: U-type, for LUI 0110111 and AUIPC 0010111.
  - 101: J-type, for JAL 1101111.
  - 110: CSR immediate, for SYSTEM 1110011 with `funct3[2]=1`.
  - 111: I-type, for SYSTEM with `funct3[2]=0` and MISC-MEM 0001111.
  - OP 0110011 uses 000 with `has_imm=0`.
  - Any other opcode uses 000 with `has_imm=0` and `illegal=1`.
- Immediate formats:
  - I: sext(`instr[31:20]`).
  - S: sext(`{instr[31:25], instr[11:7]}`).
  - B: sext(`{instr[31], instr[7], instr[30:25], instr[11:8], 0}`).
  - U: `{instr[31:12], 12'h000}`.
  - J: sext(`{instr[31], instr[19:12], instr[20], instr[30:21], 0}`).
  - CSR: zero-extended `instr[19:15]`.
- Decode happens combinationally on the input side. Decoded fields are registered into the main entry, or into the skid entry when the main entry is stalled.
- Buffer FSM states are EMPTY, ONE (main valid) and FULL (main and skid valid):
  - EMPTY: `in_valid` moves to ONE.
  - ONE: accept without pop moves to FULL. Accept with pop stays in ONE; the new entry replaces main. Pop without accept moves to EMPTY.
  - FULL: `in_ready=0`. A pop moves skid into main and goes to ONE.
- `in_ready` is a registered signal, equal to `state != FULL`. It never depends combinationally on `out_ready`.
- `out_valid = (state != EMPTY)`. All `out_*` fields come from the main entry.
- Accept condition is `in_valid & in_ready`. Pop condition is `out_valid & out_ready`.
- Instruction order is preserved.
- `flush` goes to EMPTY next cycle and overrides any same-cycle accept and pop. The input presented during the flush cycle is discarded.
- Reset state: EMPTY, `in_ready=1`, `out_valid=0`, and every data output is 0.
- Reset asserted mid-operation immediately clears the state and drops `out_valid`; it does not wait for a clock edge.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with `out_valid` at edge N, visible in cycle N+1.
- Throughput is one instruction per cycle while `out_ready=1`.
- A single-cycle stall of `out_ready` costs no input bubble, because the skid entry absorbs it.
- `in_ready` deasserts in the cycle after the buffer fills. It reasserts the cycle after the first pop from FULL.
- While `out_valid=1 & out_ready=0`, all `out_*` signals are held stable.
- The first valid entry after `flush` or `rst` deassertion can be accepted in the same cycle that `in_ready` is high.

## Test plan
- Send back-to-back with `out_ready=1`:
  - 0xFFF00093 (ADDI -1) gives imm 0xFFFFFFFF, type 000.
  - 0x0020A423 (SW +8) gives 0x00000008, type 010.
  - 0xFE000EE3 (BEQ −4) gives 0xFFFFFFFC, type 011.
  - 0x123452B7 (LUI) gives 0x12345000, type 100.
  - Check 1-cycle latency.
- Send 0x3002D073 (CSRRWI, zimm 5): imm 0x00000005, type 110, `has_imm=1`. Send 0x00000033 (ADD): `has_imm=0`, `illegal=0`. Send 0x0000007F: `illegal=1`.
- Hold `out_ready=0` for 3 cycles while streaming:
  - Two entries are accepted, then `in_ready=0`.
  - After releasing, outputs drain in order with no loss or duplication.
- Randomised `in_valid`/`out_ready` over 1000 instructions: the scoreboard must show in-order delivery, stable outputs during stalls, and the decode matching the reference model.
- Assert `flush` in state FULL together with `in_valid=1`: next cycle `out_valid=0`, `in_ready=1`, and the flushed input never appears.
- Assert `rst` asynchronously mid-stream, between clock edges: `out_valid` drops immediately and `out_imm=0`. After release, the first new instruction decodes correctly.
